mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single port of the hierarchical memory (RAM/IO/RNG/VGARAM) between
//  the CPU and the sprite-blit DMA engine. Owner FSM with burst cap prevents starvation.
//  Routes 1-cycle-latency read data back to the requester that issued the read.
//  Sits between cpu/dma and memory; drives addr, writeEn, readEn, writeData.
// PARAMETERS
//  WIDTH      16  address/data width
//  MAX_BURST  8   max granted transfers per ownership when the other side is waiting
// PORTS
//  clk           in   1      system clock, rising edge
//  rst_n         in   1      asynchronous, active-low reset
//  cpu_req       in   1      CPU requests one transfer this cycle
//  cpu_we        in   1      1=write, 0=read
//  cpu_addr      in   WIDTH  CPU address
//  cpu_wdata     in   WIDTH  CPU write data
//  cpu_gnt       out  1      CPU transfer accepted this cycle
//  cpu_rvalid    out  1      cpu_rdata valid (read issued previous cycle)
//  cpu_rdata     out  WIDTH  read data
//  dma_req/we/addr/wdata/gnt/rvalid/rdata  same as cpu_*, for the DMA engine
//  dma_lock      in   1      DMA holds bus past MAX_BURST (atomic sprite row)
//  mem_addr      out  WIDTH  memory address
//  mem_writeEn   out  1      memory write strobe
//  mem_readEn    out  1      memory read strobe
//  mem_writeData out  WIDTH  memory write data
//  mem_readData  in   WIDTH  memory read data, valid 1 cycle after mem_readEn
// BEHAVIOUR
//  - Reset: owner=IDLE, burst_cnt=0, rd tag cleared; all gnt/rvalid/mem strobes 0;
//    mem_addr/mem_writeData 0. Pending read return in flight at reset is dropped.
//  - Registered owner FSM {IDLE, CPU, DMA}; gnt/mem outputs combinational from owner.
//  - x_gnt = (owner==x) & x_req. mem_* mux selected by owner; strobes gated by gnt:
//    mem_writeEn = gnt & we, mem_readEn = gnt & ~we. No strobe in IDLE.
//  - IDLE: next = cpu_req ? CPU : dma_req ? DMA : IDLE (1-cycle arbitration bubble;
//    simultaneous requests from IDLE -> CPU).
//  - CPU: !cpu_req -> (dma_req ? DMA : IDLE); cpu_req & dma_req & burst_cnt==MAX_BURST-1
//    -> DMA; else stay.
//  - DMA: !dma_req -> (cpu_req ? CPU : IDLE); dma_req & dma_lock -> stay regardless of
//    count; cpu_req & burst_cnt==MAX_BURST-1 & !dma_lock -> CPU; else stay.
//  - burst_cnt: +1 per granted transfer, cleared on owner change, saturates at MAX_BURST-1.
//    Lock release with burst_cnt saturated and cpu_req high -> handover on that edge.
//  - Read return: on a granted read, tag<={1,owner} at the edge; next cycle the tagged
//    side's rvalid=1. cpu_rdata=dma_rdata=mem_readData (broadcast); only rvalid is steered.
//    Back-to-back reads 1/cycle; handover cycle may carry the previous owner's rvalid.
//  - Writes complete in the grant cycle; no response.
//  - Requester must hold req/we/addr/wdata stable until gnt.
// CONFIGURATION
//  ARB_STATS_EN defined: adds outputs cpu_wait_cnt, dma_wait_cnt (16 b each):
//    increment every cycle x_req=1 & x_gnt=0, saturate at 16'hFFFF, clear on reset.
//  Not defined: ports and counters absent; arbitration identical.
// TESTING
//  1 Reset: rst_n=0 mid read -> all gnt/rvalid/strobes 0 immediately; no rvalid after release.
//  2 CPU solo: write 16'h0010<=16'hBEEF, read 16'h0010 -> cpu_gnt after 1 idle cycle,
//    cpu_rvalid next cycle with cpu_rdata=16'hBEEF; dma_rvalid stays 0.
//  3 Contention: both req from IDLE continuously -> CPU gets 8 grants, DMA 8, alternating.
//  4 Lock: DMA owns, dma_lock=1, cpu_req=1 for 20 cycles -> DMA keeps all 20 grants;
//    drop lock -> CPU owns next cycle.
//  5 Tag steering: DMA read at handover cycle -> dma_rvalid=1, cpu_rvalid=0 next cycle.
//  6 ARB_STATS_EN: CPU blocked 8 cycles by DMA -> cpu_wait_cnt=8; stuck for 70000 -> 16'hFFFF.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: lets the CPU and the sprite-blit DMA engine share the single
// memory port. A registered owner FSM (IDLE/CPU/DMA) with a burst cap hands the
// bus over when the other side is waiting. dma_lock lets the DMA keep the bus
// past the cap. Read data has a 1-cycle latency. The data is sent to both
// requesters, and only the rvalid of the side that issued the read is raised.
// Optional feature macro: ARB_STATS_EN adds the per-requester wait counters
// cpu_wait_cnt and dma_wait_cnt.
module mem_bus_arbiter #(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic             cpu_gnt,
  output logic             cpu_rvalid,
  output logic [WIDTH-1:0] cpu_rdata,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [WIDTH-1:0] dma_addr,
  input  logic [WIDTH-1:0] dma_wdata,
  input  logic             dma_lock,
  output logic             dma_gnt,
  output logic             dma_rvalid,
  output logic [WIDTH-1:0] dma_rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_writeEn,
  output logic             mem_readEn,
  output logic [WIDTH-1:0] mem_writeData,
  input  logic [WIDTH-1:0] mem_readData
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]      cpu_wait_cnt,
  output logic [15:0]      dma_wait_cnt
`endif
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);
  localparam logic [CW-1:0] BURST_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2
  } owner_e;

  owner_e          owner_q, owner_d;
  logic [CW-1:0]   burst_q, burst_d;
  logic            tag_vld_q;
  logic            tag_dma_q;
  logic            burst_sat_s;
  logic            gnt_any_s;
  logic            sel_we_s;

  assign burst_sat_s = (burst_q == BURST_LAST);

  // Owner mux: route the owner's request onto the memory port and gate the strobes by grant.
  always_comb begin
    mem_addr      = {WIDTH{1'b0}};
    mem_writeData = {WIDTH{1'b0}};
    sel_we_s      = 1'b0;
    gnt_any_s     = 1'b0;
    case (owner_q)
      ST_CPU: begin
        mem_addr      = cpu_addr;
        mem_writeData = cpu_wdata;
        sel_we_s      = cpu_we;
        gnt_any_s     = cpu_req;
      end
      ST_DMA: begin
        mem_addr      = dma_addr;
        mem_writeData = dma_wdata;
        sel_we_s      = dma_we;
        gnt_any_s     = dma_req;
      end
      default: begin
        mem_addr      = {WIDTH{1'b0}};
        mem_writeData = {WIDTH{1'b0}};
        sel_we_s      = 1'b0;
        gnt_any_s     = 1'b0;
      end
    endcase
  end

  assign cpu_gnt     = (owner_q == ST_CPU) & cpu_req;
  assign dma_gnt     = (owner_q == ST_DMA) & dma_req;
  assign mem_writeEn = gnt_any_s & sel_we_s;
  assign mem_readEn  = gnt_any_s & ~sel_we_s;

  // Next owner: CPU wins ties from IDLE, and the burst cap hands over unless the DMA holds the lock.
  always_comb begin
    owner_d = owner_q;
    case (owner_q)
      ST_IDLE: begin
        if (cpu_req)      owner_d = ST_CPU;
        else if (dma_req) owner_d = ST_DMA;
        else              owner_d = ST_IDLE;
      end
      ST_CPU: begin
        if (!cpu_req)                    owner_d = dma_req ? ST_DMA : ST_IDLE;
        else if (dma_req && burst_sat_s) owner_d = ST_DMA;
        else                             owner_d = ST_CPU;
      end
      ST_DMA: begin
        if (!dma_req)                    owner_d = cpu_req ? ST_CPU : ST_IDLE;
        else if (dma_lock)               owner_d = ST_DMA;
        else if (cpu_req && burst_sat_s) owner_d = ST_CPU;
        else                             owner_d = ST_DMA;
      end
      default: owner_d = ST_IDLE;
    endcase
  end

  // Burst count: restarts on every ownership change and saturates at the cap.
  always_comb begin
    burst_d = burst_q;
    if (owner_d != owner_q)            burst_d = {CW{1'b0}};
    else if (gnt_any_s && !burst_sat_s) burst_d = burst_q + BURST_ONE;
    else                               burst_d = burst_q;
  end

  // Owner FSM state, burst counter and read-return tag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= ST_IDLE;
      burst_q   <= {CW{1'b0}};
      tag_vld_q <= 1'b0;
      tag_dma_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      burst_q   <= burst_d;
      tag_vld_q <= mem_readEn;
      tag_dma_q <= (owner_q == ST_DMA);
    end
  end

  assign cpu_rvalid = tag_vld_q & ~tag_dma_q;
  assign dma_rvalid = tag_vld_q &  tag_dma_q;
  assign cpu_rdata  = mem_readData;
  assign dma_rdata  = mem_readData;

`ifdef ARB_STATS_EN
  // Wait statistics: count cycles each side requests without a grant, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_wait_cnt <= 16'h0000;
      dma_wait_cnt <= 16'h0000;
    end else begin
      if (cpu_req && !cpu_gnt && (cpu_wait_cnt != 16'hFFFF)) cpu_wait_cnt <= cpu_wait_cnt + 16'h0001;
      else                                                   cpu_wait_cnt <= cpu_wait_cnt;
      if (dma_req && !dma_gnt && (dma_wait_cnt != 16'hFFFF)) dma_wait_cnt <= dma_wait_cnt + 16'h0001;
      else                                                   dma_wait_cnt <= dma_wait_cnt;
    end
  end
`endif

endmodule
